// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, 2-flop column sync, full-scan debounce, key FSM.
// Optional auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_SCANS   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_INVALID} res_kind_e;
    typedef enum logic {ST_RELEASED, ST_PRESSED} state_e;

    logic [3:0]    sync1_q, sync2_q;
    logic [CW-1:0] dwell_q;
    logic [1:0]    row_q;
    logic [11:0]   snap_q;
    res_kind_e     prev_kind_q;
    logic [3:0]    prev_code_q;
    logic [DW-1:0] stab_q, stab_d;
    state_e        state_q, state_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;

    logic [3:0]  pressed;
    logic        sample, scan_done, same, accept;
    logic [15:0] snap_full;
    logic [4:0]  hits;
    logic [3:0]  hit_code, res_code;
    res_kind_e   res_kind;

    assign pressed   = ~sync2_q;
    assign sample    = (dwell_q == CW'(SCAN_DIV - 1));
    assign scan_done = sample && (row_q == 2'd3);
    assign row_n     = ~(4'b0001 << row_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == ST_PRESSED);

    // Row 3 is never stored: its columns join the snapshot live at the final sample point.
    always_comb begin
        snap_full = {pressed, snap_q};
        hits      = '0;
        hit_code  = '0;
        res_code  = '0;
        res_kind  = RES_NONE;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                hits     = hits + 5'd1;
                hit_code = 4'(i);
            end
        end
        if (hits == 5'd1) begin
            res_kind = RES_KEY;
            res_code = hit_code;
        end else if (hits != 5'd0) begin
            res_kind = RES_INVALID;
        end
    end

    always_comb begin
        same   = (res_kind == prev_kind_q) && (res_code == prev_code_q);
        stab_d = DW'(1);
        if (same) stab_d = (stab_q == DB_MAX) ? stab_q : stab_q + DW'(1);
        accept = scan_done && (stab_d == DB_MAX) && (res_kind != RES_INVALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            dwell_q     <= '0;
            row_q       <= '0;
            snap_q      <= '0;
            prev_kind_q <= RES_NONE;
            prev_code_q <= '0;
            stab_q      <= '0;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            if (sample) begin
                dwell_q <= '0;
                row_q   <= row_q + 2'd1;
                case (row_q)
                    2'd0:    snap_q[3:0]  <= pressed;
                    2'd1:    snap_q[7:4]  <= pressed;
                    2'd2:    snap_q[11:8] <= pressed;
                    default: ;
                endcase
            end else begin
                dwell_q <= dwell_q + CW'(1);
            end
            if (scan_done) begin
                prev_kind_q <= res_kind;
                prev_code_q <= res_code;
                stab_q      <= stab_d;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_SCANS) ? REPEAT_DELAY : REPEAT_SCANS;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_nxt;
    logic          rpt_first_q, rpt_first_d;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_nxt     = rpt_cnt_q + RW'(1);
`endif
        unique case (state_q)
            ST_RELEASED: begin
                if (accept && res_kind == RES_KEY) begin
                    state_d = ST_PRESSED;
                    code_d  = res_code;
                    valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end
            end
            ST_PRESSED: begin
                if (accept) begin
                    if (res_kind == RES_NONE) begin
                        state_d = ST_RELEASED;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_d = '0;
`endif
                    end else if (res_code != code_q) begin
                        code_d  = res_code;
                        valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b1;
`endif
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_nxt == (rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_SCANS))) begin
                        valid_d     = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_nxt;
                    end
`endif
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASED;
            code_q  <= '0;
            valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: per-scan key sets drive a keypad model; expected pulses are queued.
module tb_keypad_scanner;

    localparam int unsigned SD = 4, DB = 2, RD = 3, RS = 2, SCAN = 4 * SD;
    localparam int NONE = 16, INV = 17;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] col_n, row_n, key_code;
    logic       key_valid, key_held;
    logic [15:0] keys = '0;

    typedef struct {
        logic [3:0]  code;
        int unsigned cyc;
    } exp_t;
    exp_t exp_q[$];

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned cyc = 0;
    int          hist[$];
    bit          m_pressed = 1'b0;
    logic [3:0]  m_code = '0;
    int unsigned scan_k = 0, rpt_n = 0;

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column to the row currently driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_DELAY(RD), .REPEAT_SCANS(RS)) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [15:0] k);
        int idx = 0;
        if ($countones(k) == 0) return NONE;
        if ($countones(k) > 1)  return INV;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        return idx;
    endfunction

    function automatic void push_pulse(input logic [3:0] c);
        exp_t e;
        e.code = c;
        e.cyc  = SCAN * (scan_k + 1);
        exp_q.push_back(e);
    endfunction

    // Reference: a result is accepted once the last DB scan results agree and are not INVALID.
    function automatic void model_scan(input logic [15:0] k);
        int  r = classify(k);
        bit  acc;
        hist.push_back(r);
        if (hist.size() > DB) void'(hist.pop_front());
        acc = (hist.size() == DB) && (r != INV);
        foreach (hist[i]) if (hist[i] != r) acc = 1'b0;
        if (acc) begin
            if (!m_pressed && r != NONE) begin
                m_pressed = 1'b1; m_code = 4'(r); rpt_n = 0; push_pulse(m_code);
            end else if (m_pressed && r == NONE) begin
                m_pressed = 1'b0;
            end else if (m_pressed && 4'(r) != m_code) begin
                m_code = 4'(r); rpt_n = 0; push_pulse(m_code);
            end else if (m_pressed) begin
`ifdef KEYPAD_REPEAT_EN
                rpt_n++;
                if (rpt_n == RD || (rpt_n > RD && (rpt_n - RD) % RS == 0)) push_pulse(m_code);
`endif
            end
        end
        scan_k++;
    endfunction

    // Called on a falling edge at a scan boundary; returns on the falling edge ending that scan.
    task automatic run_scan(input logic [15:0] k);
        keys = k;
        model_scan(k);
        repeat (SCAN) @(posedge clk);
        @(negedge clk);
        chk("key_held", {31'b0, key_held}, {31'b0, m_pressed});
        chk("key_code", {28'b0, key_code}, {28'b0, m_code});
    endtask

    task automatic run_n(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_scan(k);
    endtask

    task automatic check_reset_outputs();
        chk("rst_row_n", {28'b0, row_n}, 32'he);
        chk("rst_key_code", {28'b0, key_code}, 32'h0);
        chk("rst_key_valid", {31'b0, key_valid}, 32'h0);
        chk("rst_key_held", {31'b0, key_held}, 32'h0);
    endtask

    function automatic void model_reset();
        hist.delete();
        m_pressed = 1'b0;
        m_code    = '0;
        scan_k    = 0;
        rpt_n     = 0;
    endfunction

    // Monitor: row sequence every cycle, and every key_valid pulse against the queued expectation.
    initial begin
        exp_t       e;
        logic [3:0] exp_row;
        #2;
        forever begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((cyc / SD) % 4));
            chk("row_n", {28'b0, row_n}, {28'b0, exp_row});
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("valid_missing_cycle", cyc, e.cyc);
            end
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", {31'b0, key_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("valid_code", {28'b0, key_code}, {28'b0, e.code});
                    chk("held_on_valid", {31'b0, key_held}, 32'h1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout, %0d pulses still pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] k;
        int unsigned a, b;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        run_n('0, 3);
        // Clean press of row 2 / col 1, then release.
        run_n(16'h0200, 4);
        run_n('0, 3);
        // Single-scan press must be filtered.
        run_n(16'h0001, 1);
        run_n('0, 3);
        // Ghosting pair, then one key lifted.
        run_n(16'h0060, 5);
        run_n(16'h0020, 3);
        run_n('0, 3);
        // Direct rollover 0x3 -> 0xC.
        run_n(16'h0008, 3);
        run_n(16'h1000, 3);

        // Reset in the middle of row 2 while 0xC is still held.
        repeat (2 * SD + 1) @(posedge clk);
        @(negedge clk);
        chk("row_before_reset", {28'b0, row_n}, 32'hb);
        chk("pending_at_reset", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_n(16'h1000, 3);
        run_n('0, 3);

        // Long hold of 0x7 (auto-repeat when built in).
        run_n(16'h0080, 12);
        run_n('0, 3);

        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            k = '0;
            case ($urandom_range(0, 3))
                0:       k = '0;
                3:       begin k[a] = 1'b1; k[(a + 1 + b % 15) % 16] = 1'b1; end
                default: k[a] = 1'b1;
            endcase
            run_n(k, int'($urandom_range(1, 4)));
        end
        run_n('0, 3);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad: drives one row low at a time, reads the active-low columns, debounces over full scans, emits a 4-bit key code with a one-cycle valid strobe.
- Input-side counterpart of the multiplexed seven-segment driver. Row strobing mirrors digit strobing; column sensing replaces segment driving.
- Sits between the board keypad pins and control FSMs, such as the ping-pong counter max/min load path.

Parameters:
- SCAN_DIV, 50000: clk cycles each row is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required before a result is accepted; minimum 1.
- REPEAT_DELAY, 50: scans a key must be held before the first auto-repeat; used only with KEYPAD_REPEAT_EN.
- REPEAT_SCANS, 10: scans between subsequent auto-repeats; used only with KEYPAD_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- col_n, input, 4: keypad columns, active-low, externally pulled up, asynchronous to clk.
- row_n, output, 4: keypad row drive, exactly one bit low at all times.
- key_code, output, 4: code of the last accepted key, {row[1:0], col[1:0]}.
- key_valid, output, 1: one-cycle pulse when key_code is updated with a new press.
- key_held, output, 1: high while the accepted key remains stably pressed.

Behaviour:
- Reset (async assert, clk-synchronous deassert behaviour follows from registers):
  - row_n=4'b1110; key_code=0; key_valid=0; key_held=0.
  - dwell counter, row index, snapshot, debounce counter and synchronizer flops all clear; FSM in RELEASED.
- Column synchronizer:
  - 2-flop synchronizer on col_n; the sampled value is the inverted synchronized vector.
- Scan timing:
  - Dwell counter counts 0..SCAN_DIV-1 per row.
  - Columns are sampled on count SCAN_DIV-1, which allows drive settling plus synchronizer latency.
  - Row index then advances 0→1→2→3→0; row_n = ~(1<<row).
  - One full scan = 4*SCAN_DIV cycles. Row drive never pauses, including during debounce or reset of the debounce logic.
- Scan result, formed at the sample point of row 3 from a 16-bit pressed snapshot:
  - Exactly one bit set → result = that key's code.
  - Zero bits set → result = NONE.
  - Two or more bits set (ghosting/multi-press) → result = INVALID.
- Debounce:
  - Compare each result with the previous scan's result; equal → increment the stability counter (saturating); different → reset it to 1.
  - A result is accepted when the counter reaches DEBOUNCE_SCANS.
  - INVALID is never accepted; it holds the current FSM state unchanged.
- FSM, evaluated once per completed scan:
  - RELEASED, accepted code K → key_code=K, key_valid pulses 1 cycle, key_held=1, go to PRESSED.
  - RELEASED, accepted NONE → stay.
  - PRESSED, accepted same K → stay; no pulse.
  - PRESSED, accepted different K' → key_code=K', key_valid pulse, stay PRESSED (direct rollover).
  - PRESSED, accepted NONE → key_held=0, go to RELEASED; key_code retains its last value.
- key_valid timing: asserted in the cycle after row-3 sample of the accepting scan, for exactly 1 clk.
- Boundary conditions:
  - Press shorter than DEBOUNCE_SCANS scans → no output.
  - Bounce inside a scan only matters at sample instants.
  - rst_n asserted mid-scan or mid-pulse → outputs go to reset values immediately; the scan restarts at row 0.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a scan counter starts at acceptance.
  - After REPEAT_DELAY further scans with the same K accepted, key_valid re-pulses with unchanged key_code, then again every REPEAT_SCANS scans.
  - Rollover or release restarts or clears the counter.
- Undefined: no repeat counter is built; key_valid pulses only on a new press or rollover.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2, scan = 16 cycles.
- Reset: hold rst_n=0 → row_n=4'b1110, key_code=0, key_valid=0, key_held=0. Release reset, keep col_n=4'hF → row_n sequence 1110,1101,1011,0111 with 4 cycles each, and no key_valid ever.
- Clean press: model key row 2 / col 1 (col_n bit1 low while row_n=1011) → exactly one key_valid pulse with key_code=4'h9 at the end of the 2nd full scan; key_held=1. Release → key_held=0 two scans later; key_code stays 9.
- Short press: key row0/col0 for 1 scan only → no key_valid, key_held stays 0.
- Ghosting: keys 0x5 and 0x6 pressed together for 5 scans → no pulse. Then 0x6 is released (0x5 alone) → one pulse with key_code=5.
- Rollover and mid-operation reset: hold 0x3 until accepted, then switch directly to 0xC → second pulse with key_code=C and key_held never drops. Assert rst_n mid-row-2 → immediate reset values, scan resumes at row 0.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=3, REPEAT_SCANS=2: hold 0x7 for 12 scans → pulses at acceptance, +3 scans, +5, +7, +9, all with key_code=7. Without the macro → one pulse only.
